vec_store_writer: RTL
=====================

// Module: vec_store_writer
// PURPOSE
// Vector store path into the byte-wide image data memory; the write-side counterpart of the
// 8-lane vector load port. Accepts one 16-lane x 16-bit vector register plus a base byte address.
// Serialises lanes 0..LANES-1 into single-byte writes, one per cycle, clamping each lane to
// PIX_SIZE bits. Sits between the vector execute stage and the data-memory write port.
// PARAMETERS
// IMAGE_WIDTH   96  image width in pixels
// IMAGE_HEIGHT  96  image height in pixels; memory depth = IMAGE_WIDTH*IMAGE_HEIGHT bytes
// PIX_SIZE      8   pixel/byte width written to memory
// LANES         8   lanes stored per request (1..16); lanes LANES..15 of WD ignored
// PORTS
// CLK       in   1          clock, all state updates on rising edge
// RST       in   1          asynchronous, active-high reset
// Start     in   1          request strobe, sampled only in IDLE
// Addr      in   16         base byte address of lane 0
// WD        in   [15:0][15:0] vector data, lane i = WD[i], signed 16-bit
// LaneMask  in   16         per-lane write enable; bit i gates lane i
// Busy      out  1          high while a request is in progress
// Done      out  1          one-cycle pulse after the last lane slot
// MemWE     out  1          byte write enable to data memory
// MemAddr   out  16         byte address for current write
// MemWD     out  PIX_SIZE   byte data for current write
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, Busy=0, Done=0, MemWE=0, MemAddr=0, MemWD=0,
//   lane counter=0, latched vector/address/mask cleared.
// - States: IDLE -> WRITE -> DONE -> IDLE.
//   IDLE: Start=1 latches Addr, WD, LaneMask; counter=0; next=WRITE.
//   WRITE: exactly LANES cycles, one lane slot per cycle, counter 0..LANES-1; after slot LANES-1
//   next=DONE.
//   DONE: Done=1 for this single cycle, Busy=0, next=IDLE.
// - Busy=1 in WRITE only; Start while Busy or in DONE is ignored (not queued).
// - Inputs are sampled only at the accepting edge; later changes to Addr/WD/LaneMask
//   have no effect on the request in flight.
// - Slot k (WRITE, counter=k), registered outputs:
//   MemAddr = latched Addr + k (16-bit, wraps modulo 2^16); MemWD = clamp(WD[k]).
//   MemWE = LaneMask[k] AND (MemAddr <= IMAGE_WIDTH*IMAGE_HEIGHT-1).
// - Out-of-range addresses are silently skipped (no write) but still consume their slot.
//   The request still completes with Done.
// - Clamp: WD[k] negative (bit15=1) -> 0; WD[k] > 2^PIX_SIZE-1 -> 2^PIX_SIZE-1;
//   otherwise the low PIX_SIZE bits.
// - Timing: Start accepted at edge E0 -> slots at cycles E1..E(LANES), Done at E(LANES+1).
//   A new Start is accepted at E(LANES+2) at the earliest. Latency fixed regardless of mask.
// - Outside WRITE: MemWE=0; MemAddr/MemWD hold their last values.
// - Reset mid-request aborts it: remaining lanes are not written, no Done is produced.
//   Memory bytes already written stay written.
// TESTING
// 1. Addr=100, WD[i]=i+1, mask=16'hFFFF, Start 1 cycle -> MemWE=1 for 8 cycles,
//    writes (100,1)..(107,8); Done one cycle later.
// 2. WD[0]=16'hFFFF (-1), WD[1]=300, WD[2]=255, WD[3]=16'h0080 -> MemWD 0, 255, 255, 128.
// 3. Addr=9212, mask all ones -> writes only at 9212..9215; slots 4..7 have MemWE=0;
//    Done at same cycle as case 1.
// 4. Addr=16'hFFFE -> MemAddr 65534, 65535, 0, 1..5; writes at 0..5 allowed (in range),
//    65534/65535 suppressed.
// 5. LaneMask=16'h00A5 -> MemWE high only in slots 0, 2, 5, 7.
//    Start pulsed in slot 3 is ignored: still exactly one Done, no second request.
// 6. Assert RST in slot 4 of a request -> MemWE/Busy/Done drop to 0 asynchronously,
//    no Done follows. Next Start after reset runs a full, correct request.

Source files
------------

// File: rtl/vec_store_writer.sv
// Vector store writer: serialises up to 16 clamped lanes of a latched
// vector into single-byte writes to the image data memory.
module vec_store_writer #(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int PIX_SIZE     = 8,
  parameter int LANES        = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [15:0]          Addr,
  input  logic [15:0][15:0]    WD,
  input  logic [15:0]          LaneMask,
  output logic                 Busy,
  output logic                 Done,
  output logic                 MemWE,
  output logic [15:0]          MemAddr,
  output logic [PIX_SIZE-1:0]  MemWD
);

  localparam int          DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [3:0]  LAST  = 4'(LANES - 1);
  localparam logic [16:0] MAXV  = 17'((1 << PIX_SIZE) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0][15:0]   wd_q, wd_d;
  logic [15:0]         mask_q, mask_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [15:0]         maddr_q, maddr_d;
  logic [PIX_SIZE-1:0] mwd_q, mwd_d;

  logic [15:0]         lane;
  logic [15:0]         slot_addr;
  logic                in_range;
  logic [PIX_SIZE-1:0] lane_clamped;

  assign lane      = wd_q[cnt_q];
  assign slot_addr = addr_q + {12'd0, cnt_q};
  assign in_range  = ({16'd0, slot_addr} < 32'(DEPTH));

  // Saturate a signed lane into the unsigned pixel range.
  always_comb begin
    lane_clamped = lane[PIX_SIZE-1:0];
    if (lane[15]) begin
      lane_clamped = '0;
    end else if ({1'b0, lane} > MAXV) begin
      lane_clamped = '1;
    end
  end

  // State and latched-request registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      mask_q  <= mask_d;
    end
  end

  // Next state: accept in IDLE, step one lane per cycle in WRITE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    mask_d  = mask_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d  = Addr;
          wd_d    = WD;
          mask_d  = LaneMask;
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: memory port values for the current lane slot.
  always_comb begin
    busy_d  = (state_q == S_WRITE);
    done_d  = (state_q == S_DONE);
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    if (state_q == S_WRITE) begin
      maddr_d = slot_addr;
      mwd_d   = lane_clamped;
      we_d    = mask_q[cnt_q] & in_range;
    end
  end

  // Registered outputs; address/data hold outside WRITE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign MemWE   = we_q;
  assign MemAddr = maddr_q;
  assign MemWD   = mwd_q;

endmodule
